// File: rtl/sweep_pkg.sv
// Shared constants for the truth-table sweeper: FSM encoding, vector count and widths.
package sweep_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int unsigned N_VEC = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 5;

endpackage

// File: rtl/settle_timer.sv
// Per-vector settle counter: counts up from zero while enabled, flags the last settle cycle.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 4'd1;
    end
  end

  assign expired = (count == 4'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 16 {a,b,c,d} combinations, samples f_in after a settle delay,
// and builds the 16-bit truth table and its ones count.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  ones_cnt
);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             expired;

  // The timer is held cleared outside SETTLE so each vector starts counting from zero.
  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != SETTLE),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      table_out <= '0;
      ones_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= '0;
            table_out <= '0;
            ones_cnt  <= '0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (expired) state <= SAMPLE;
        end
        SAMPLE: begin
          table_out[idx] <= f_in;
          ones_cnt       <= ones_cnt + CNT_W'(f_in);
          if (idx == IDX_W'(N_VEC - 1)) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= SETTLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign {a, b, c, d} = idx;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper with SETTLE_CYCLES of 1 and 3.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, start1, f1, a1, b1, c1, d1, busy1, done1;
  logic [15:0] tab1;
  logic [4:0]  ones1;
  logic        rst3, start3, f3, a3, b3, c3, d3, busy3, done3;
  logic [15:0] tab3;
  logic [4:0]  ones3;

  // Behavioural combinational block under test: a 16-entry function plus optional glitch.
  logic [15:0] fnv    = '0;
  logic        glitch = 1'b0;
  assign f1 = fnv[{a1, b1, c1, d1}] ^ glitch;
  assign f3 = fnv[{a3, b3, c3, d3}] ^ glitch;

  truth_table_sweeper #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .f_in(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .table_out(tab1), .ones_cnt(ones1)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(3)) u3 (
    .clk(clk), .rst(rst3), .start(start3), .f_in(f3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
    .table_out(tab3), .ones_cnt(ones3)
  );

  int          sel = 1;
  logic [3:0]  vec_s;
  logic        busy_s, done_s;
  logic [15:0] tab_s;
  logic [4:0]  ones_s;

  always_comb begin
    if (sel == 1) begin
      vec_s = {a1, b1, c1, d1}; busy_s = busy1; done_s = done1; tab_s = tab1; ones_s = ones1;
    end else begin
      vec_s = {a3, b3, c3, d3}; busy_s = busy3; done_s = done3; tab_s = tab3; ones_s = ones3;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 1) start1 = v; else start3 = v;
  endtask

  // Reference truth table from the boolean rule, index i = {a,b,c,d}.
  function automatic logic [15:0] build_fn(input int mode);
    logic [15:0] r;
    logic [3:0]  v;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      case (mode)
        0:       r[i] = v[3] & v[2];
        1:       r[i] = v[0];
        3:       r[i] = ^v;
        4:       r[i] = v[1];
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic sweep(input int s, input logic [15:0] fn, input logic [15:0] exp_tab,
                       input logic [4:0] exp_ones, input bit do_glitch, input bit extra,
                       input string nm);
    int S, m, nd, nb;
    bit hold_ok, pulsed;
    S = (s == 1) ? 1 : 3;
    sel = s; fnv = fn; glitch = 1'b0;
    @(negedge clk); set_start(s, 1'b1);
    @(posedge clk); #1;
    m = 0; hold_ok = 1'b1; pulsed = 1'b0;
    while (!done_s && m < 200) begin
      if (m < 16 * (S + 1) && vec_s != 4'(m / (S + 1))) hold_ok = 1'b0;
      if (!busy_s) hold_ok = 1'b0;
      @(negedge clk);
      set_start(s, extra && !pulsed && vec_s == 4'd3);
      if (extra && vec_s == 4'd3) pulsed = 1'b1;
      // Sample edges fall every S+1 edges after acceptance; glitch only between them.
      glitch = do_glitch && (((m + 1) % (S + 1)) != 0) && ($urandom_range(1, 0) == 1);
      @(posedge clk); #1;
      m++;
    end
    glitch = 1'b0;
    check({nm, " latency"}, m, 16 * (S + 1));
    check({nm, " table"}, tab_s, exp_tab);
    check({nm, " ones"}, ones_s, exp_ones);
    check({nm, " vector hold"}, hold_ok, 1);
    check({nm, " busy at done"}, busy_s, 1);
    check({nm, " vec at done"}, vec_s, 4'hF);
    @(negedge clk); set_start(s, extra);
    @(posedge clk); #1;
    check({nm, " done one cycle"}, done_s, 0);
    check({nm, " busy after"}, busy_s, 0);
    @(negedge clk); set_start(s, 1'b0);
    nd = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_s) nd++;
      if (busy_s) nb++;
    end
    check({nm, " no extra done"}, nd, 0);
    check({nm, " stays idle"}, nb, 0);
    check({nm, " table held"}, tab_s, exp_tab);
  endtask

  typedef struct {
    int          s;
    int          mode;
    logic [15:0] exp_tab;
    logic [4:0]  exp_ones;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] rf;
    int          s, n, cyc, ndone;
    int          t[3];

    vecs[0] = '{1, 0, 16'hF000, 5'd4};
    vecs[1] = '{1, 1, 16'hAAAA, 5'd8};
    vecs[2] = '{1, 2, 16'h0000, 5'd0};
    vecs[3] = '{3, 3, 16'h6996, 5'd8};
    vecs[4] = '{3, 4, 16'hCCCC, 5'd8};
    vecs[5] = '{1, 4, 16'hCCCC, 5'd8};

    rst1 = 1'b1; rst3 = 1'b1; start1 = 1'b0; start3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 1; k <= 3; k += 2) begin
      sel = k; #1;
      check("reset vec", vec_s, 0);
      check("reset busy", busy_s, 0);
      check("reset done", done_s, 0);
      check("reset table", tab_s, 0);
      check("reset ones", ones_s, 0);
    end
    @(negedge clk); rst1 = 1'b0; rst3 = 1'b0;

    for (int k = 0; k < 6; k++)
      sweep(vecs[k].s, build_fn(vecs[k].mode), vecs[k].exp_tab, vecs[k].exp_ones,
            1'b0, 1'b0, $sformatf("vec%0d", k));

    for (int k = 0; k < 6; k++) begin
      s  = ($urandom_range(1, 0) == 1) ? 3 : 1;
      rf = 16'($urandom);
      sweep(s, rf, rf, 5'($countones(rf)), 1'b1, 1'b0, $sformatf("rand%0d", k));
    end

    sweep(1, build_fn(0), 16'hF000, 5'd4, 1'b0, 1'b1, "extra_start");

    // Abort mid-sweep with a partially filled table.
    sel = 1; fnv = 16'($urandom) | 16'h00FF;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    n = 0;
    while (vec_s != 4'd7 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("reach idx7", vec_s, 7);
    @(negedge clk); rst1 = 1'b1;
    @(posedge clk); #1;
    check("abort vec", vec_s, 0);
    check("abort busy", busy_s, 0);
    check("abort done", done_s, 0);
    check("abort table", tab_s, 0);
    check("abort ones", ones_s, 0);
    @(negedge clk); rst1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort stays idle", busy_s, 0);
    rf = 16'($urandom);
    sweep(1, rf, rf, 5'($countones(rf)), 1'b0, 1'b0, "after_abort");

    // Start held high: back-to-back sweeps.
    sel = 1; fnv = build_fn(4);
    @(negedge clk); start1 = 1'b1;
    ndone = 0; cyc = 0;
    while (ndone < 3 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (done_s) begin
        t[ndone] = cyc;
        check($sformatf("held table %0d", ndone), tab_s, 16'hCCCC);
        check($sformatf("held ones %0d", ndone), ones_s, 8);
        ndone++;
      end
    end
    @(negedge clk); start1 = 1'b0;
    check("held done count", ndone, 3);
    if (ndone == 3) begin
      check("held spacing 1", t[1] - t[0], 34);
      check("held spacing 2", t[2] - t[1], 34);
    end
    repeat (40) @(posedge clk);
    #1;
    check("held final idle", busy_s, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
